// File: rtl/clock_divider.sv
// clock_divider: integer clock divider producing a registered square wave
// at Clock_in / DIVISOR and a one-cycle tick on each Clock_out rising edge.
// Everything runs on the single input clock; both outputs come straight off
// flops, so downstream logic sees clean, glitch-free signals.
module clock_divider #(
  parameter int WIDTH   = 28,
  parameter int DIVISOR = 2
) (
  input  logic Clock_in,
  output logic Clock_out,
  input  logic Reset,
  output logic Tick_out
);

  // Refuse to build with a ratio the counter cannot represent.
  if (DIVISOR < 1 || longint'(DIVISOR) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_divisor
    $fatal(1, "clock_divider: DIVISOR %0d out of range for WIDTH %0d", DIVISOR, WIDTH);
  end

  // Last count value before wrapping, and the count at which the output goes high.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(DIVISOR - 1);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(DIVISOR / 2);

  logic [WIDTH-1:0] cnt;

  // Count 0..DIVISOR-1 and derive both outputs from the pre-update count.
  always_ff @(posedge Clock_in) begin
    if (Reset) begin
      cnt       <= '0;
      Clock_out <= 1'b0;
      Tick_out  <= 1'b0;
    end else begin
      cnt       <= (cnt == LAST) ? '0 : cnt + WIDTH'(1);
      Clock_out <= (cnt >= HALF);
      Tick_out  <= (cnt == HALF);
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: drives several divider instances (different ratios,
// including DIVISOR=1 and the largest ratio a 3-bit counter allows) from a
// shared clock and reset, and compares every output on every edge against a
// model built from "edges since reset release modulo DIVISOR".
module tb_clock_divider;

  localparam int NUM_DUTS = 6;

  // Ratio and counter width of each instance under test.
  function automatic int divOf(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 5;
      4: return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int widthOf(input int i);
    return (i == 4) ? 3 : 28;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkOut [NUM_DUTS];
  logic tickOut[NUM_DUTS];

  int checkCount = 0;
  int passCount  = 0;
  int sinceRelease = 0;
  bit midResetDone = 1'b0;

  // Free-running input clock.
  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_DUTS; g++) begin : g_dut
    logic co;
    logic to;
    clock_divider #(
      .WIDTH  (widthOf(g)),
      .DIVISOR(divOf(g))
    ) dut (
      .Clock_in (clk),
      .Clock_out(co),
      .Reset    (rst),
      .Tick_out (to)
    );
    assign clkOut[g]  = co;
    assign tickOut[g] = to;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Choose the reset level for the coming edge.
  task automatic applyStimulus(input int cycle);
    if (cycle < 3) begin
      rst = 1'b1;
    end else if (cycle < 120) begin
      // One directed single-cycle reset while the DIVISOR=4 output is high.
      if (!midResetDone && cycle > 60 && (sinceRelease % 4) == 3) begin
        rst = 1'b1;
        midResetDone = 1'b1;
      end else begin
        rst = 1'b0;
      end
    end else begin
      rst = ($urandom_range(15) == 0);
    end
  endtask

  initial begin
    int d;
    logic expOut;
    logic expTick;
    for (int cycle = 0; cycle < 900; cycle++) begin
      @(negedge clk);
      applyStimulus(cycle);
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_DUTS; i++) begin
        d = divOf(i);
        if (rst) begin
          expOut  = 1'b0;
          expTick = 1'b0;
        end else begin
          expOut  = ((sinceRelease % d) >= (d / 2));
          expTick = ((sinceRelease % d) == (d / 2));
        end
        checkOutput($sformatf("clk_out D=%0d cyc=%0d", d, cycle), clkOut[i], expOut);
        checkOutput($sformatf("tick D=%0d cyc=%0d", d, cycle), tickOut[i], expTick);
      end
      if (rst) sinceRelease = 0;
      else     sinceRelease++;
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
